// File: rtl/axi_isolate_ctrl.sv
// Power-down / power-up sequencer for an axi_isolate instance.
// Isolates the downstream AXI port, waits for drain, then gates its clock;
// on release it ungates first and de-isolates afterwards.
module axi_isolate_ctrl #(
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned GateDelay     = 4,
  parameter int unsigned UngateDelay   = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  output logic ack_o,
  output logic isolate_o,
  input  logic isolated_i,
  output logic clk_en_o,
  output logic busy_o,
  output logic timeout_o
);

  localparam int unsigned MaxTg    = (TimeoutCycles > GateDelay) ? TimeoutCycles : GateDelay;
  localparam int unsigned MaxDelay = (MaxTg > UngateDelay) ? MaxTg : UngateDelay;
  localparam int unsigned CntWidth = (MaxDelay > 0) ? $clog2(MaxDelay + 1) : 1;

  localparam logic [CntWidth-1:0] TimeoutLast =
      CntWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 32'd0);
  localparam logic [CntWidth-1:0] GateLast =
      CntWidth'((GateDelay > 0) ? GateDelay - 1 : 32'd0);
  localparam logic [CntWidth-1:0] UngateLast =
      CntWidth'((UngateDelay > 0) ? UngateDelay - 1 : 32'd0);
  localparam logic [CntWidth-1:0] CntMax = '1;

  typedef enum logic [2:0] {
    StRun,
    StDrain,
    StGateWait,
    StOff,
    StUngate,
    StRelease
  } state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d, cnt_inc;
  logic                timeout_q, timeout_d;
  logic                req_seen_low_q, req_seen_low_d;
  logic                isolate_q, isolate_d;
  logic                clk_en_q, clk_en_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;

  // Next-state, counter, sticky error and re-request qualification.
  always_comb begin
    state_d        = state_q;
    cnt_inc        = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    cnt_d          = cnt_inc;
    timeout_d      = timeout_q;
    // After a timeout the requester must drop req_i before it may re-request.
    req_seen_low_d = req_seen_low_q | ~req_i;
    unique case (state_q)
      StRun: begin
        if (req_i && req_seen_low_q) begin
          state_d   = StDrain;
          timeout_d = 1'b0;
        end
      end
      StDrain: begin
        if (isolated_i) begin
          state_d = (GateDelay == 0) ? StOff : StGateWait;
        end else if (!req_i) begin
          state_d = StRun;
        end else if ((TimeoutCycles != 0) && (cnt_q == TimeoutLast)) begin
          state_d        = StRun;
          timeout_d      = 1'b1;
          req_seen_low_d = 1'b0;
        end
      end
      StGateWait: begin
        if (cnt_q == GateLast) state_d = StOff;
      end
      StOff: begin
        if (!req_i) state_d = (UngateDelay == 0) ? StRelease : StUngate;
      end
      StUngate: begin
        if (cnt_q == UngateLast) state_d = StRelease;
      end
      StRelease: begin
        if (!isolated_i) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Output decode of the next state so outputs change together with the state.
  always_comb begin
    isolate_d = 1'b0;
    clk_en_d  = 1'b1;
    ack_d     = 1'b0;
    unique case (state_d)
      StRun:      begin isolate_d = 1'b0; clk_en_d = 1'b1; ack_d = 1'b0; end
      StDrain:    begin isolate_d = 1'b1; clk_en_d = 1'b1; ack_d = 1'b0; end
      StGateWait: begin isolate_d = 1'b1; clk_en_d = 1'b1; ack_d = 1'b0; end
      StOff:      begin isolate_d = 1'b1; clk_en_d = 1'b0; ack_d = 1'b1; end
      StUngate:   begin isolate_d = 1'b1; clk_en_d = 1'b1; ack_d = 1'b1; end
      StRelease:  begin isolate_d = 1'b0; clk_en_d = 1'b1; ack_d = 1'b1; end
      default:    begin isolate_d = 1'b0; clk_en_d = 1'b1; ack_d = 1'b0; end
    endcase
    busy_d = (state_d != StRun) && (state_d != StOff);
  end

  // State and registered outputs; reset drops straight back to the running state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StRun;
      cnt_q          <= '0;
      timeout_q      <= 1'b0;
      req_seen_low_q <= 1'b1;
      isolate_q      <= 1'b0;
      clk_en_q       <= 1'b1;
      ack_q          <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      timeout_q      <= timeout_d;
      req_seen_low_q <= req_seen_low_d;
      isolate_q      <= isolate_d;
      clk_en_q       <= clk_en_d;
      ack_q          <= ack_d;
      busy_q         <= busy_d;
    end
  end

  assign isolate_o = isolate_q;
  assign clk_en_o  = clk_en_q;
  assign ack_o     = ack_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

`ifndef SYNTHESIS
  // Clock may only be off while the port is isolated and drained.
  a_gated_isolated: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !clk_en_o |-> (isolate_o && isolated_i));

  a_deiso_clocked: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $fell(isolate_o) |-> clk_en_o);

  a_ack_handshake: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (ack_o != $past(ack_o)) |-> ($past(req_i) != $past(ack_o)));

  // Downstream must stay drained once it reported isolated.
  a_gate_wait_drained: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == StGateWait) |-> isolated_i);
`endif

endmodule

// File: tb/tb_axi_isolate_ctrl.sv
// Directed bench for axi_isolate_ctrl: one instance with nonzero delays and
// a 16-cycle timeout, one with zero delays and the timeout disabled.
module tb_axi_isolate_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  logic a_req, a_iso_in, a_ack, a_iso, a_clk_en, a_busy, a_to;
  logic z_req, z_iso_in, z_ack, z_iso, z_clk_en, z_busy, z_to;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_isolate_ctrl #(
    .TimeoutCycles(16),
    .GateDelay    (4),
    .UngateDelay  (4)
  ) dut_a (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (a_req),
    .ack_o     (a_ack),
    .isolate_o (a_iso),
    .isolated_i(a_iso_in),
    .clk_en_o  (a_clk_en),
    .busy_o    (a_busy),
    .timeout_o (a_to)
  );

  axi_isolate_ctrl #(
    .TimeoutCycles(0),
    .GateDelay    (0),
    .UngateDelay  (0)
  ) dut_z (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (z_req),
    .ack_o     (z_ack),
    .isolate_o (z_iso),
    .isolated_i(z_iso_in),
    .clk_en_o  (z_clk_en),
    .busy_o    (z_busy),
    .timeout_o (z_to)
  );

  // Packed as {isolate, clk_en, ack, busy, timeout}.
  logic [4:0] a_out, z_out;
  assign a_out = {a_iso, a_clk_en, a_ack, a_busy, a_to};
  assign z_out = {z_iso, z_clk_en, z_ack, z_busy, z_to};

  typedef struct {
    int         n;
    logic       req;
    logic       iso;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got iso/clk/ack/busy/to=%b expected %b", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Normal cycle, GateDelay=4: RUN->DRAIN->GATE_WAIT->OFF->UNGATE->RELEASE->RUN
    vecs[0]  = '{1,  1'b1, 1'b0, 5'b11010};
    vecs[1]  = '{9,  1'b1, 1'b0, 5'b11010};
    vecs[2]  = '{1,  1'b1, 1'b1, 5'b11010};
    vecs[3]  = '{3,  1'b1, 1'b1, 5'b11010};
    vecs[4]  = '{1,  1'b1, 1'b1, 5'b10100};
    vecs[5]  = '{15, 1'b1, 1'b1, 5'b10100};
    vecs[6]  = '{1,  1'b0, 1'b1, 5'b11110};
    vecs[7]  = '{3,  1'b0, 1'b1, 5'b11110};
    vecs[8]  = '{1,  1'b0, 1'b1, 5'b01110};
    vecs[9]  = '{2,  1'b0, 1'b1, 5'b01110};
    vecs[10] = '{1,  1'b0, 1'b0, 5'b01000};
    // Abort during drain
    vecs[11] = '{5,  1'b1, 1'b0, 5'b11010};
    vecs[12] = '{1,  1'b0, 1'b0, 5'b01000};
    // Timeout after 16 drain cycles, then re-request gating
    vecs[13] = '{1,  1'b1, 1'b0, 5'b11010};
    vecs[14] = '{15, 1'b1, 1'b0, 5'b11010};
    vecs[15] = '{1,  1'b1, 1'b0, 5'b01001};
    vecs[16] = '{5,  1'b1, 1'b0, 5'b01001};
    vecs[17] = '{1,  1'b0, 1'b0, 5'b01001};
    vecs[18] = '{1,  1'b1, 1'b0, 5'b11010};
    // isolated_i on the timeout cycle wins
    vecs[19] = '{15, 1'b1, 1'b0, 5'b11010};
    vecs[20] = '{1,  1'b1, 1'b1, 5'b11010};
    vecs[21] = '{4,  1'b1, 1'b1, 5'b10100};
    vecs[22] = '{5,  1'b0, 1'b1, 5'b01110};
    vecs[23] = '{1,  1'b0, 1'b0, 5'b01000};
    vecs[24] = '{1,  1'b1, 1'b0, 5'b11010};
    vecs[25] = '{1,  1'b0, 1'b0, 5'b01000};

    rst_n    = 1'b0;
    a_req    = 1'b0;
    a_iso_in = 1'b0;
    z_req    = 1'b0;
    z_iso_in = 1'b0;
    tick(3);
    check("reset_a", a_out, 5'b01000);
    check("reset_z", z_out, 5'b01000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      a_req    = vecs[i].req;
      a_iso_in = vecs[i].iso;
      tick(vecs[i].n);
      check($sformatf("vec%0d", i), a_out, vecs[i].exp);
    end

    // Zero delays, timeout disabled
    z_req = 1'b1;
    tick(1);
    check("z_drain", z_out, 5'b11010);
    tick(20);
    check("z_no_timeout", z_out, 5'b11010);
    z_iso_in = 1'b1;
    tick(1);
    check("z_gate_direct", z_out, 5'b10100);
    z_req = 1'b0;
    tick(1);
    check("z_release_direct", z_out, 5'b01110);
    z_iso_in = 1'b0;
    tick(1);
    check("z_run", z_out, 5'b01000);
    z_req = 1'b1;
    tick(1);
    z_iso_in = 1'b1;
    tick(1);
    check("z_off_again", z_out, 5'b10100);

    // Asynchronous reset while gated
    #2;
    rst_n = 1'b0;
    #1;
    check("z_async_reset", z_out, 5'b01000);
    z_req    = 1'b0;
    z_iso_in = 1'b0;
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("z_after_reset", z_out, 5'b01000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
